// File: rtl/divider_16x8_seq.sv
// divider_16x8_seq
// Sequential 16-by-8 restoring divider for the NPU rescale/normalisation
// path. It runs in signed (two's complement) or unsigned mode and resolves
// one quotient bit per clock.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   In_1        16-bit dividend (two's complement when Sign=1)
//   In_2        8-bit divisor   (two's complement when Sign=1)
//   Sign        1 = signed division, 0 = unsigned; sampled with the operands
//   In_Valid    operands present
//   In_Ready    block can accept a job (high only in IDLE)
//   Quotient    16-bit quotient
//   Remainder   8-bit remainder; it takes the dividend's sign
//   Div_By_Zero divisor was zero; valid with Out_Valid
//   Overflow    signed -32768 / -1; valid with Out_Valid
//   Out_Valid   result present (high only in DONE)
//   Out_Ready   consumer accepts the result
//
// Latency: a normal job takes 17 edges after the accept (16 DIV + 1 FIX).
// A zero-divisor or overflow job goes to DONE on the accepting edge.
module divider_16x8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] In_1,
  input  logic [7:0]  In_2,
  input  logic        Sign,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic [15:0] Quotient,
  output logic [7:0]  Remainder,
  output logic        Div_By_Zero,
  output logic        Overflow,
  output logic        Out_Valid,
  input  logic        Out_Ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Conditional two's-complement negation. It gives absolute values on entry
  // and restores signs on exit. Because the result is unsigned, the negation
  // of 16'h8000 stays 16'h8000, which is the correct magnitude 32768.
  function automatic logic [15:0] neg16(input logic [15:0] v, input logic en);
    return en ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [7:0] neg8(input logic [7:0] v, input logic en);
    return en ? (~v + 8'd1) : v;
  endfunction

  logic signed [15:0] dividend_s;
  logic signed [7:0]  divisor_s;
  logic               dvd_neg;
  logic               dvs_neg;
  logic               accept;
  logic               div_zero;
  logic               sgn_ovf;

  assign dividend_s = $signed(In_1);
  assign divisor_s  = $signed(In_2);
  assign dvd_neg    = Sign & (dividend_s < 16'sd0);
  assign dvs_neg    = Sign & (divisor_s < 8'sd0);
  assign accept     = In_Valid & In_Ready;
  assign div_zero   = (In_2 == 8'd0);
  assign sgn_ovf    = Sign & (In_1 == 16'h8000) & (In_2 == 8'hFF);

  // Working registers. They hold only data, so they are not reset.
  // quo_p starts as the dividend magnitude. Each step shifts one dividend
  // bit out of the top and one quotient bit in at the bottom.
  logic [15:0] quo_p;
  logic [7:0]  rem_p;
  logic [7:0]  div_mag_p;
  logic        q_neg_p;
  logic        r_neg_p;
  logic [3:0]  step_cnt;

  // One restoring step. The partial remainder after each step is below the
  // divisor magnitude (at most 255), so it fits in 8 bits. The trial value
  // before the compare needs 9 bits.
  logic [8:0] rem_trial;
  logic [8:0] rem_sub;
  logic       q_bit;
  logic [7:0] rem_next;

  always_comb begin
    rem_trial = {rem_p, quo_p[15]};
    rem_sub   = rem_trial - {1'b0, div_mag_p};
    q_bit     = (rem_trial >= {1'b0, div_mag_p});
    rem_next  = q_bit ? 8'(rem_sub) : 8'(rem_trial);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    case (state)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          if (div_zero || sgn_ovf) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DIV;
          end
        end
      end
      DIV: begin
        if (step_cnt == 4'd15) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Step counter and result registers. The result registers are held
  // through DONE and IDLE. Only the accept edge (special cases) and the FIX
  // edge write them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt    <= 4'd0;
      Quotient    <= 16'd0;
      Remainder   <= 8'd0;
      Div_By_Zero <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            step_cnt <= 4'd0;
            if (div_zero) begin
              Quotient    <= 16'hFFFF;
              Remainder   <= In_1[7:0];
              Div_By_Zero <= 1'b1;
              Overflow    <= 1'b0;
            end else if (sgn_ovf) begin
              Quotient    <= 16'h8000;
              Remainder   <= 8'd0;
              Div_By_Zero <= 1'b0;
              Overflow    <= 1'b1;
            end else begin
              Div_By_Zero <= 1'b0;
              Overflow    <= 1'b0;
            end
          end
        end
        DIV: begin
          step_cnt <= step_cnt + 4'd1;
        end
        FIX: begin
          Quotient  <= neg16(quo_p, q_neg_p);
          Remainder <= neg8(rem_p, r_neg_p);
        end
        default: begin
        end
      endcase
    end
  end

  // Operand capture at accept, then the restoring iteration in DIV.
  // Truncating division: the quotient is negative when the operand signs
  // differ, and the remainder follows the dividend's sign.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo_p     <= neg16(In_1, dvd_neg);
      div_mag_p <= neg8(In_2, dvs_neg);
      rem_p     <= 8'd0;
      q_neg_p   <= dvd_neg ^ dvs_neg;
      r_neg_p   <= dvd_neg;
    end else if (state == DIV) begin
      quo_p <= {quo_p[14:0], q_bit};
      rem_p <= rem_next;
    end
  end

endmodule

// File: tb/tb_divider_16x8_seq.sv
module tb_divider_16x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In_1;
  logic [7:0]  In_2;
  logic        Sign;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        Div_By_Zero;
  logic        Overflow;
  logic        Out_Valid;
  logic        Out_Ready;

  always #5 clk = ~clk;

  divider_16x8_seq dut (
    .clk        (clk),
    .rst        (rst),
    .In_1       (In_1),
    .In_2       (In_2),
    .Sign       (Sign),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .Div_By_Zero(Div_By_Zero),
    .Overflow   (Overflow),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model built on the simulator's integer division, which
  // truncates toward zero and gives the remainder the dividend's sign.
  function automatic exp_t model(input logic s, input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int   dd;
    int   dv;
    int   qi;
    int   ri;
    e = '0;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
    end else if (s && a == 16'h8000 && b == 8'hFF) begin
      e.q   = 16'h8000;
      e.ovf = 1'b1;
    end else begin
      if (s) begin
        dd = int'($signed(a));
        dv = int'($signed(b));
      end else begin
        dd = int'({16'd0, a});
        dv = int'({24'd0, b});
      end
      qi  = dd / dv;
      ri  = dd % dv;
      e.q = qi[15:0];
      e.r = ri[7:0];
    end
    return e;
  endfunction

  task automatic run_job(input logic s, input logic [15:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    e = model(s, a, b);
    @(negedge clk);
    Sign      = s;
    In_1      = a;
    In_2      = b;
    In_Valid  = 1'b1;
    Out_Ready = (hold == 0);
    check("in_ready_idle", In_Ready, 1);
    sb.push_back(e);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    In_Valid = 1'b0;
    while (!Out_Valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, (e.dbz || e.ovf) ? 0 : 17);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        In_Valid = 1'b1;
        Sign     = 1'b0;
        In_1     = 16'd50;
        In_2     = 8'd5;
      end else begin
        In_Valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", Out_Valid, 1);
      check("hold_in_ready", In_Ready, 0);
      check("hold_quotient", Quotient, e.q);
      check("hold_remainder", Remainder, e.r);
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    check("sb_nonempty", sb.size(), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
    end else begin
      got = e;
    end
    check("quotient", Quotient, got.q);
    check("remainder", Remainder, got.r);
    check("div_by_zero", Div_By_Zero, got.dbz);
    check("overflow", Overflow, got.ovf);
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", Out_Valid, 0);
    check("post_in_ready", In_Ready, 1);
  endtask

  initial begin
    int stray;
    rst       = 1'b1;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    Sign      = 1'b0;
    In_1      = 16'd0;
    In_2      = 8'd0;
    #1;
    check("rst_out_valid", Out_Valid, 0);
    check("rst_in_ready", In_Ready, 1);
    check("rst_quotient", Quotient, 0);
    check("rst_remainder", Remainder, 0);
    check("rst_dbz", Div_By_Zero, 0);
    check("rst_ovf", Overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed jobs
    run_job(1'b0, 16'd1000, 8'd7, 0);
    run_job(1'b1, 16'hFF9C, 8'h07, 0);
    run_job(1'b1, 16'd100, 8'hF9, 0);
    run_job(1'b0, 16'hFFFF, 8'hFF, 0);
    run_job(1'b1, 16'h1234, 8'h00, 0);
    run_job(1'b0, 16'h1234, 8'h00, 0);
    run_job(1'b1, 16'h8000, 8'hFF, 0);
    run_job(1'b0, 16'h8000, 8'hFF, 0);
    run_job(1'b1, 16'h8000, 8'h80, 0);
    run_job(1'b1, 16'h7FFF, 8'h01, 0);

    // Random jobs
    for (int k = 0; k < 8; k++) begin
      run_job(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 0);
    end

    // Backpressure: hold the result 10 cycles with a stray In_Valid pulse
    run_job(1'b1, 16'hFF9C, 8'h07, 10);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (Out_Valid) stray++;
    end
    check("ignored_pulse", stray, 0);

    // Reset in the middle of DIV
    @(negedge clk);
    Sign     = 1'b0;
    In_1     = 16'd1000;
    In_2     = 8'd7;
    In_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_quotient", Quotient, 0);
    check("midrst_remainder", Remainder, 0);
    check("midrst_dbz", Div_By_Zero, 0);
    check("midrst_ovf", Overflow, 0);
    check("midrst_out_valid", Out_Valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", In_Ready, 1);
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (Out_Valid) stray++;
    end
    check("discarded_job", stray, 0);

    run_job(1'b0, 16'd1000, 8'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
